// File: rtl/spi_cmd_pkg.sv
// Shared opcodes and FSM state encoding for the SPI command decoder.
package spi_cmd_pkg;

    localparam logic [7:0] OP_WRITE   = 8'h02;
    localparam logic [7:0] OP_READ    = 8'h03;
    localparam logic [7:0] OP_READ_ID = 8'h9F;

    typedef enum logic [3:0] {
        IDLE,
        CMD,
        ADDR,
        WDATA,
        RD_REQ,
        RD_WAIT,
        RDATA,
        DONE,
        SKIP
    } state_t;

endpackage

// File: rtl/spi_cmd_rd_timer.sv
// Loadable down-counter that flags when a register read has waited too long.
module spi_cmd_rd_timer #(
    parameter int MAX = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_load,
    input  logic i_en,
    output logic o_expired
);
    localparam int W = $clog2(MAX + 1);

    logic [W-1:0] r_count;

    // Holds at zero once expired so the decoder sees a steady timeout flag.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= W'(MAX);
        end else if (i_en && (r_count != '0)) begin
            r_count <= r_count - W'(1);
        end
    end

    assign o_expired = (r_count == '0);

endmodule

// File: rtl/spi_cmd_decoder.sv
// Parses SPI byte frames (CMD, ADDR, DATA...) into register-bus reads and writes.
// Define SPI_CMD_AUTO_INC_EN to enable burst writes/reads with address auto-increment.
module spi_cmd_decoder
    import spi_cmd_pkg::*;
#(
    parameter logic [7:0] ID_VALUE    = 8'hA5,
    parameter logic [7:0] DUMMY_BYTE  = 8'h00,
    parameter int         RD_WAIT_MAX = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    input  logic       cs_idle,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    output logic [7:0] reg_addr,
    output logic [7:0] reg_wdata,
    output logic       reg_we,
    output logic       reg_re,
    input  logic [7:0] reg_rdata,
    input  logic       reg_rvalid,
    output logic       frame_err
);

    state_t r_state;
    logic   r_is_read;
    logic   w_tmr_load;
    logic   w_tmr_en;
    logic   w_tmr_expired;

    assign w_tmr_load = (r_state == RD_REQ);
    assign w_tmr_en   = (r_state == RD_WAIT);

    spi_cmd_rd_timer #(
        .MAX(RD_WAIT_MAX)
    ) u_rd_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_load   (w_tmr_load),
        .i_en     (w_tmr_en),
        .o_expired(w_tmr_expired)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_is_read <= 1'b0;
            tx_data   <= DUMMY_BYTE;
            tx_valid  <= 1'b0;
            reg_addr  <= 8'h00;
            reg_wdata <= 8'h00;
            reg_we    <= 1'b0;
            reg_re    <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            tx_valid  <= 1'b0;
            reg_we    <= 1'b0;
            reg_re    <= 1'b0;
            frame_err <= 1'b0;
`ifdef SPI_CMD_AUTO_INC_EN
            if (reg_we) begin
                reg_addr <= reg_addr + 8'd1;
            end
`endif
            case (r_state)
                IDLE: begin
                    if (!cs_idle) begin
                        r_state <= CMD;
                    end
                end
                CMD: begin
                    if (rx_valid) begin
                        case (rx_data)
                            OP_WRITE: begin
                                r_is_read <= 1'b0;
                                r_state   <= ADDR;
                            end
                            OP_READ: begin
                                r_is_read <= 1'b1;
                                r_state   <= ADDR;
                            end
                            OP_READ_ID: begin
                                tx_data  <= ID_VALUE;
                                tx_valid <= 1'b1;
                                r_state  <= DONE;
                            end
                            default: begin
                                frame_err <= 1'b1;
                                r_state   <= SKIP;
                            end
                        endcase
                    end
                end
                ADDR: begin
                    if (rx_valid) begin
                        reg_addr <= rx_data;
                        r_state  <= r_is_read ? RD_REQ : WDATA;
                    end else if (cs_idle) begin
                        frame_err <= 1'b1;
                    end
                end
                WDATA: begin
                    if (rx_valid) begin
                        reg_wdata <= rx_data;
                        reg_we    <= 1'b1;
`ifndef SPI_CMD_AUTO_INC_EN
                        r_state   <= SKIP;
`endif
                    end
                end
                RD_REQ: begin
                    // A byte arriving before the read completes means the master outran the bus.
                    if (rx_valid) begin
                        frame_err <= 1'b1;
                        r_state   <= SKIP;
                    end else if (!cs_idle) begin
                        reg_re  <= 1'b1;
                        r_state <= RD_WAIT;
                    end
                end
                RD_WAIT: begin
                    if (cs_idle || rx_valid) begin
                        frame_err <= 1'b1;
                        r_state   <= SKIP;
                    end else if (reg_rvalid) begin
                        tx_data  <= reg_rdata;
                        tx_valid <= 1'b1;
                        r_state  <= RDATA;
                    end else if (w_tmr_expired) begin
                        tx_data   <= DUMMY_BYTE;
                        tx_valid  <= 1'b1;
                        frame_err <= 1'b1;
                        r_state   <= SKIP;
                    end
                end
                RDATA: begin
                    if (rx_valid) begin
`ifdef SPI_CMD_AUTO_INC_EN
                        reg_addr <= reg_addr + 8'd1;
                        r_state  <= RD_REQ;
`else
                        r_state  <= SKIP;
`endif
                    end
                end
                DONE, SKIP: begin
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
            // Chip-select release ends the frame after any same-cycle byte has been handled.
            if (cs_idle) begin
                r_state <= IDLE;
            end
        end
    end

endmodule
